cu_factorial: RTL and testbench

CU_FACTORIAL -- requirements
Module: cu_factorial

---
 rtl/cu_factorial.sv | 135 +++++++++++++
 tb/tb_cu_factorial.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cu_factorial.sv
// Control unit for an iterative factorial datapath: sequences counter load/decrement
// and product accumulation, and reports done/error through a four-phase handshake with go.
module cu_factorial (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       err,
    input  logic       gt,
    output logic       load_cnt,
    output logic       en,
    output logic       load_reg,
    output logic       sel1,
    output logic       sel2,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] iter
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHK   = 3'd2,
        MUL   = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] iter_q, iter_d;
    logic       load_cnt_q, load_cnt_d;
    logic       en_q, en_d;
    logic       load_reg_q, load_reg_d;
    logic       sel1_q, sel1_d;
    logic       sel2_q, sel2_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = INIT;
            INIT:    state_d = CHK;
            CHK: begin
                if (err)     state_d = ERROR;
                else if (gt) state_d = MUL;
                else         state_d = DONE;
            end
            MUL:     state_d = CHK;
            DONE,
            ERROR:   if (!go) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they stay a
    // pure function of the state register while being glitch-free at the pins.
    always_comb begin
        load_cnt_d = 1'b0;
        en_d       = 1'b0;
        load_reg_d = 1'b0;
        sel1_d     = 1'b0;
        sel2_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_d)
            INIT: begin
                load_cnt_d = 1'b1;
                load_reg_d = 1'b1;
                busy_d     = 1'b1;
            end
            CHK:  busy_d = 1'b1;
            MUL: begin
                en_d       = 1'b1;
                load_reg_d = 1'b1;
                sel1_d     = 1'b1;
                busy_d     = 1'b1;
            end
            DONE: begin
                sel2_d = 1'b1;
                done_d = 1'b1;
            end
            ERROR:   error_d = 1'b1;
            default: ;
        endcase
    end

    // MUL is only ever entered from CHK and lasts one cycle, so every MUL is a fresh entry.
    always_comb begin
        iter_d = iter_q;
        if (state_d == INIT)
            iter_d = 4'd0;
        else if (state_d == MUL && iter_q != 4'd15)
            iter_d = iter_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            iter_q     <= 4'd0;
            load_cnt_q <= 1'b0;
            en_q       <= 1'b0;
            load_reg_q <= 1'b0;
            sel1_q     <= 1'b0;
            sel2_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            load_cnt_q <= load_cnt_d;
            en_q       <= en_d;
            load_reg_q <= load_reg_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign load_cnt = load_cnt_q;
    assign en       = en_q;
    assign load_reg = load_reg_q;
    assign sel1     = sel1_q;
    assign sel2     = sel2_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign iter     = iter_q;

endmodule

// File: tb/tb_cu_factorial.sv
// Scoreboard bench for cu_factorial: a behavioural factorial datapath closes the loop,
// stimulus pushes expected results, and a monitor checks them when done/error rises.
module tb_cu_factorial;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        err, gt;
    logic        load_cnt, en, load_reg, sel1, sel2, busy, done, error;
    logic [3:0]  iter;

    logic [3:0]  n_val = 4'd0;
    logic [3:0]  cnt_q = 4'd0;
    logic [31:0] prod_q = 32'd0;
    logic [31:0] product;
    int          cycle = 0;
    int          en_count = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic        done_prev = 1'b0;
    logic        error_prev = 1'b0;

    typedef struct {
        bit          exp_done;
        bit          exp_error;
        logic [31:0] exp_product;
        int          exp_iter;
        int          start;
        int          lat;
    } exp_t;

    exp_t sb[$];

    cu_factorial dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .err      (err),
        .gt       (gt),
        .load_cnt (load_cnt),
        .en       (en),
        .load_reg (load_reg),
        .sel1     (sel1),
        .sel2     (sel2),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .iter     (iter)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: down-counter, product register and comparator flags.
    assign err     = (n_val > 4'd12);
    assign gt      = (cnt_q > 4'd1);
    assign product = sel2 ? prod_q : 32'd0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (load_cnt)  cnt_q <= n_val;
        else if (en)   cnt_q <= cnt_q - 4'd1;
        if (load_reg)  prod_q <= sel1 ? prod_q * {28'd0, cnt_q} : 32'd1;
        if (load_cnt)  en_count <= 0;
        else if (en)   en_count <= en_count + 1;
    end

    // Reference result from the arithmetic definition of n! and the latency rules.
    function automatic exp_t model(int n, int start);
        exp_t r;
        longint p = 1;
        r.start = start;
        if (n > 12) begin
            r.exp_done    = 1'b0;
            r.exp_error   = 1'b1;
            r.exp_product = 32'd0;
            r.exp_iter    = 0;
            r.lat         = 2;
        end else begin
            for (int k = 2; k <= n; k++) p = p * k;
            r.exp_done    = 1'b1;
            r.exp_error   = 1'b0;
            r.exp_product = p[31:0];
            r.exp_iter    = (n >= 2) ? ((n - 1 > 15) ? 15 : n - 1) : 0;
            r.lat         = (n >= 2) ? 2 + 2 * (n - 1) : 2;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares each result as it is presented by the DUT.
    always @(negedge clk) begin
        exp_t e;
        if (reset && ((done && !done_prev) || (error && !error_prev))) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("done", done, e.exp_done);
                checkOutput("error", error, e.exp_error);
                checkOutput("product", product, e.exp_product);
                checkOutput("iter", iter, e.exp_iter);
                checkOutput("latency", cycle - e.start, e.lat);
                checkOutput("en_cycles", en_count, e.exp_iter);
                checkOutput("busy_at_result", busy, 0);
            end
        end
        done_prev  <= done;
        error_prev <= error;
    end

    task automatic recoverReset();
        go = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int n, input bit wiggle);
        bit seen = 1'b0;
        int hold;
        exp_t e;
        n_val = n[3:0];
        go = 1'b1;
        e = model(n, cycle + 1);
        sb.push_back(e);
        @(posedge clk);
        for (int w = 0; w < 80 && !seen; w++) begin
            @(negedge clk);
            if (done || error) seen = 1'b1;
            else if (wiggle) go = 1'($urandom_range(0, 1));
        end
        if (!seen) begin
            checkOutput("result_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_back());
            recoverReset();
        end else begin
            go = 1'b1;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checkOutput("go_held_result", done | error, 1);
                checkOutput("go_held_busy", busy, 0);
            end
            go = 1'b0;
            @(negedge clk);
            checkOutput("idle_after_release", {busy, done, error, load_cnt, en, load_reg, sel1, sel2}, 0);
            checkOutput("iter_hold_idle", iter, e.exp_iter);
        end
    endtask

    task automatic resetDuringMul();
        bit hit = 1'b0;
        n_val = 4'd7;
        go = 1'b1;
        sb.push_back(model(7, cycle + 1));
        @(posedge clk);
        for (int w = 0; w < 40 && !hit; w++) begin
            @(negedge clk);
            if (en && iter == 4'd3) hit = 1'b1;
        end
        checkOutput("third_mul_reached", hit, 1);
        go = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {load_cnt, en, load_reg, sel1, sel2, busy, done, error}, 0);
        checkOutput("async_reset_iter", iter, 0);
        if (sb.size() != 0) void'(sb.pop_back());
        repeat (2) @(negedge clk);
        checkOutput("held_reset_outputs", {load_cnt, en, load_reg, busy, done, error}, 0);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(3, 1'b0);
    endtask

    initial begin
        int directed[5] = '{5, 0, 1, 12, 13};
        #1 reset = 1'b0;
        #1;
        checkOutput("reset_outputs", {load_cnt, en, load_reg, sel1, sel2, busy, done, error}, 0);
        checkOutput("reset_iter", iter, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", {busy, done, error}, 0);

        foreach (directed[i]) applyStimulus(directed[i], 1'b0);
        applyStimulus(5, 1'b1);
        resetDuringMul();
        for (int t = 0; t < 40; t++)
            applyStimulus(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
